// File: rtl/cd_rx_des.sv
// CDBUS receive deserializer: recovers start/8N1 characters from the oversampled line,
// tracks the running CRC-16/MODBUS per frame and ends frames by idle time.
module cd_rx_des #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] div_ls,
  input  logic [15:0] div_hs,
  input  logic [9:0]  idle_len,
  output logic        bus_idle,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_first,
  output logic        frame_end,
  output logic        crc_ok,
  output logic        frame_err,
  output logic        break_det
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        rxPrev_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic        baudSel_q, baudSel_d;
  logic        charHs_q, charHs_d;
  logic [15:0] crc_q, crc_d;
  logic [9:0]  byteCnt_q, byteCnt_d;
  logic [15:0] idleCnt_q, idleCnt_d;
  logic [9:0]  idleBits_q, idleBits_d;
  logic        busIdle_q, busIdle_d;
  logic [7:0]  rxData_q, rxData_d;
  logic        rxValid_q, rxValid_d;
  logic        rxFirst_q, rxFirst_d;
  logic        frameEnd_q, frameEnd_d;
  logic        crcOk_q, crcOk_d;
  logic        frameErr_q, frameErr_d;
  logic        breakDet_q, breakDet_d;

  logic        rxS;
  logic [9:0]  idleThr;
  logic [15:0] div;
  logic        sample;
  logic        startEdge;
  logic        idleReach;

  function automatic logic [15:0] crcUpd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign rxS       = sync_q[SYNC_STAGES-1];
  assign idleThr   = (idle_len == 10'd0) ? 10'd1 : idle_len;
  assign div       = charHs_q ? div_hs : div_ls;
  assign sample    = (cnt_q == (div >> 1));
  assign startEdge = (state_q == IDLE) && rxPrev_q && !rxS;
  // The final clock of the last idle period completes even if the line falls on it,
  // so a coincident start edge still lets the old frame close first.
  assign idleReach = (state_q == IDLE) && (idleBits_q == idleThr - 10'd1) &&
                     (idleCnt_q >= div_ls);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q >= div) ? 16'd0 : cnt_q + 16'd1;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    baudSel_d  = baudSel_q;
    charHs_d   = charHs_q;
    crc_d      = crc_q;
    byteCnt_d  = byteCnt_q;
    idleCnt_d  = idleCnt_q;
    idleBits_d = idleBits_q;
    busIdle_d  = busIdle_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    rxFirst_d  = 1'b0;
    frameEnd_d = 1'b0;
    crcOk_d    = 1'b0;
    frameErr_d = 1'b0;
    breakDet_d = 1'b0;

    if (state_q != IDLE || (!rxS && !idleReach)) begin
      idleCnt_d  = 16'd0;
      idleBits_d = 10'd0;
    end else if (idleBits_q < idleThr) begin
      if (idleCnt_q >= div_ls) begin
        idleCnt_d  = 16'd0;
        idleBits_d = idleBits_q + 10'd1;
      end else begin
        idleCnt_d = idleCnt_q + 16'd1;
      end
    end

    if (idleReach) begin
      busIdle_d = 1'b1;
      if (byteCnt_q != 10'd0) begin
        frameEnd_d = 1'b1;
        crcOk_d    = (crc_q == 16'h0000);
      end
      crc_d     = 16'hFFFF;
      byteCnt_d = 10'd0;
      baudSel_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        if (startEdge) begin
          state_d   = START;
          busIdle_d = 1'b0;
          charHs_d  = baudSel_q && !idleReach;
        end
      end
      START: begin
        if (sample) begin
          state_d  = rxS ? IDLE : DATA;
          bitIdx_d = 3'd0;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d  = {rxS, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (rxS) begin
            rxData_d  = shift_q;
            rxValid_d = 1'b1;
            rxFirst_d = (byteCnt_q == 10'd0);
            crc_d     = crcUpd(crc_q, shift_q);
            byteCnt_d = (byteCnt_q == 10'd1023) ? byteCnt_q : byteCnt_q + 10'd1;
            baudSel_d = 1'b1;
            state_d   = IDLE;
          end else if (shift_q == 8'h00) begin
            breakDet_d = 1'b1;
            crc_d      = 16'hFFFF;
            byteCnt_d  = 10'd0;
            baudSel_d  = 1'b0;
            state_d    = WAIT_HIGH;
          end else begin
            frameErr_d = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxS) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      rxPrev_q   <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      bitIdx_q   <= 3'd0;
      shift_q    <= 8'h00;
      baudSel_q  <= 1'b0;
      charHs_q   <= 1'b0;
      crc_q      <= 16'hFFFF;
      byteCnt_q  <= 10'd0;
      idleCnt_q  <= 16'd0;
      idleBits_q <= 10'd0;
      busIdle_q  <= 1'b0;
      rxData_q   <= 8'h00;
      rxValid_q  <= 1'b0;
      rxFirst_q  <= 1'b0;
      frameEnd_q <= 1'b0;
      crcOk_q    <= 1'b0;
      frameErr_q <= 1'b0;
      breakDet_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
      rxPrev_q   <= rxS;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      baudSel_q  <= baudSel_d;
      charHs_q   <= charHs_d;
      crc_q      <= crc_d;
      byteCnt_q  <= byteCnt_d;
      idleCnt_q  <= idleCnt_d;
      idleBits_q <= idleBits_d;
      busIdle_q  <= busIdle_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      rxFirst_q  <= rxFirst_d;
      frameEnd_q <= frameEnd_d;
      crcOk_q    <= crcOk_d;
      frameErr_q <= frameErr_d;
      breakDet_q <= breakDet_d;
    end
  end

  assign bus_idle  = busIdle_q;
  assign rx_data   = rxData_q;
  assign rx_valid  = rxValid_q;
  assign rx_first  = rxFirst_q;
  assign frame_end = frameEnd_q;
  assign crc_ok    = crcOk_q;
  assign frame_err = frameErr_q;
  assign break_det = breakDet_q;

endmodule

// File: tb/tb_cd_rx_des.sv
// Scoreboard bench for cd_rx_des: directed characters push expected events,
// a negedge monitor pops and compares every output pulse.
module tb_cd_rx_des;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] div_ls;
  logic [15:0] div_hs;
  logic [9:0]  idle_len;
  logic        bus_idle;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_first;
  logic        frame_end;
  logic        crc_ok;
  logic        frame_err;
  logic        break_det;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       first;
    logic       crcOk;
  } expT;

  expT sb[$];

  cd_rx_des #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .div_ls(div_ls), .div_hs(div_hs), .idle_len(idle_len),
    .bus_idle(bus_idle), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .frame_end(frame_end), .crc_ok(crc_ok), .frame_err(frame_err), .break_det(break_det)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int kind, input logic [7:0] data, input logic first, input logic crcOk);
    expT e;
    e.kind = kind; e.data = data; e.first = first; e.crcOk = crcOk;
    sb.push_back(e);
  endtask

  task automatic sendBit(input logic b, input int div);
    rx = b;
    repeat (div + 1) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int div, input logic stopLvl, input int stopPeriods);
    sendBit(1'b0, div);
    for (int i = 0; i < 8; i++) sendBit(d[i], div);
    for (int i = 0; i < stopPeriods; i++) sendBit(stopLvl, div);
    rx = 1'b1;
  endtask

  // Kinds: 0 byte, 1 frame end, 2 framing error, 3 break
  always @(negedge clk) begin
    if (!reset && (rx_valid || frame_end || frame_err || break_det)) begin
      int actKind;
      expT e;
      actKind = rx_valid ? 0 : frame_end ? 1 : frame_err ? 2 : 3;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected event: got kind %0d expected none", actKind);
      end else begin
        e = sb.pop_front();
        checkOutput("event kind", actKind, e.kind);
        if (e.kind == 0) begin
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          checkOutput("rx_first", {31'd0, rx_first}, {31'd0, e.first});
        end else if (e.kind == 1) begin
          checkOutput("crc_ok", {31'd0, crc_ok}, {31'd0, e.crcOk});
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " bus_idle"}, {31'd0, bus_idle}, 32'd0);
    checkOutput({tag, " rx_data"}, {24'd0, rx_data}, 32'd0);
    checkOutput({tag, " rx_valid"}, {31'd0, rx_valid}, 32'd0);
    checkOutput({tag, " rx_first"}, {31'd0, rx_first}, 32'd0);
    checkOutput({tag, " frame_end"}, {31'd0, frame_end}, 32'd0);
    checkOutput({tag, " crc_ok"}, {31'd0, crc_ok}, 32'd0);
    checkOutput({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
    checkOutput({tag, " break_det"}, {31'd0, break_det}, 32'd0);
  endtask

  initial begin
    int firstRise;
    reset = 1'b1; rx = 1'b1;
    div_ls = 16'd15; div_hs = 16'd3; idle_len = 10'd10;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("bus_idle after power-up idle", {31'd0, bus_idle}, 32'd1);

    // Good frame: CRC of 0x01 is 0x807E, so appending 7E 80 leaves zero residue
    pushExp(0, 8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 15, 1'b1, 1);
    pushExp(0, 8'h7E, 1'b0, 1'b0);
    applyStimulus(8'h7E, 3, 1'b1, 1);
    pushExp(0, 8'h80, 1'b0, 1'b0);
    applyStimulus(8'h80, 3, 1'b1, 1);
    pushExp(1, 8'h00, 1'b0, 1'b1);
    repeat (250) @(negedge clk);
    checkOutput("bus_idle after frame", {31'd0, bus_idle}, 32'd1);

    // Corrupted CRC byte
    pushExp(0, 8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 15, 1'b1, 1);
    pushExp(0, 8'h7E, 1'b0, 1'b0);
    applyStimulus(8'h7E, 3, 1'b1, 1);
    pushExp(0, 8'h81, 1'b0, 1'b0);
    applyStimulus(8'h81, 3, 1'b1, 1);
    pushExp(1, 8'h00, 1'b0, 1'b0);
    repeat (250) @(negedge clk);

    // Framing error, then a long break
    pushExp(2, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'hA5, 15, 1'b0, 1);
    repeat (32) @(negedge clk);
    pushExp(3, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 15, 1'b0, 20);
    repeat (250) @(negedge clk);
    checkOutput("bus_idle after break", {31'd0, bus_idle}, 32'd1);

    // Short low glitch is a false start
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (15) @(negedge clk);
    checkOutput("bus_idle drops on glitch", {31'd0, bus_idle}, 32'd0);
    repeat (135) @(negedge clk);
    checkOutput("bus_idle still low before re-idle", {31'd0, bus_idle}, 32'd0);
    repeat (50) @(negedge clk);
    checkOutput("bus_idle re-asserts after glitch", {31'd0, bus_idle}, 32'd1);

    // Reset in the middle of data bit 4 of 0x33
    sendBit(1'b0, 15);
    sendBit(1'b1, 15); sendBit(1'b1, 15); sendBit(1'b0, 15); sendBit(1'b0, 15);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("mid-byte reset");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("no rx_valid after reset", {31'd0, rx_valid}, 32'd0);
    checkOutput("no frame_end after reset", {31'd0, frame_end}, 32'd0);
    repeat (200) @(negedge clk);
    pushExp(0, 8'h01, 1'b1, 1'b0);
    applyStimulus(8'h01, 15, 1'b1, 1);
    pushExp(0, 8'h7E, 1'b0, 1'b0);
    applyStimulus(8'h7E, 3, 1'b1, 1);
    pushExp(0, 8'h80, 1'b0, 1'b0);
    applyStimulus(8'h80, 3, 1'b1, 1);
    pushExp(1, 8'h00, 1'b0, 1'b1);
    repeat (250) @(negedge clk);

    // Idle timing straight out of reset: 3 periods of 3 clocks
    div_ls = 16'd2; idle_len = 10'd3; rx = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    firstRise = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 8) checkOutput("bus_idle low before 9 clocks", {31'd0, bus_idle}, 32'd0);
      if (bus_idle && firstRise == 0) firstRise = k;
    end
    checks++;
    if (firstRise < 9 || firstRise > 9 + SYNC + 1) begin
      errors++;
      $display("[TB] FAIL bus_idle rise clock: got %0d expected 9..%0d", firstRise, 9 + SYNC + 1);
    end

    repeat (10) @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_rx_des.md
Name: cd_rx_des

Overview:
- Receive-side deserializer for the CDBUS physical layer; it is the counterpart of the TX serializer.
- Oversamples the bus line, recovers start/8-data/stop characters LSB-first and emits bytes with frame-position flags.
- Detects end-of-frame by idle time, checks the running CRC-16/MODBUS, and flags framing errors and break characters.
- Drives bus_idle, which the TX serializer uses for its transmit-permit timing.

Parameters:
- SYNC_STAGES, 2, rx metastability flops ahead of all logic (2..3).

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  raw bus line, idle high.
- div_ls  in  16  bit period minus 1, in clk cycles, for the first byte of a frame and for idle counting.
- div_hs  in  16  bit period minus 1 for bytes 2..N of a frame.
- idle_len  in  10  bit periods of continuous high that end a frame and assert bus_idle.
- bus_idle  out  1  line high for >= idle_len low-speed bit periods.
- rx_data  out  8  received byte.
- rx_valid  out  1  one-cycle strobe; rx_data valid.
- rx_first  out  1  qualifies rx_valid: first byte of a frame.
- frame_end  out  1  one-cycle pulse when idle_len is reached after at least one byte.
- crc_ok  out  1  valid with frame_end: running CRC == 0x0000.
- frame_err  out  1  one-cycle pulse: stop bit sampled low, data != 0.
- break_det  out  1  one-cycle pulse: data == 0x00 and stop bit low.

Behaviour:
- Reset values: bus_idle=0, rx_data=0, rx_valid=0, rx_first=0, frame_end=0, crc_ok=0, frame_err=0, break_det=0. Internally: sync flops=1, state=IDLE, baud_sel=ls, CRC=0xFFFF, byte count=0, in_frame=0.
- Reset mid-character discards the partial byte. No pulse outputs fire in the reset cycle or the cycle after it.
- rx_s is rx after SYNC_STAGES flops. All references to "line" below mean rx_s.
- Divisor div = baud_sel ? div_hs : div_ls. baud_sel is latched at each start-edge detect.
- Bit counter runs 0..div, so a bit period is div+1 clocks. The sample point is cnt == div>>1. Legal div >= 2; smaller values are unsupported.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a falling edge of rx_s (previous 1, current 0), clear cnt and go to START. The idle counter is cleared.
  - START: at the sample point, line=1 is a false start: return to IDLE with no output. Line=0: go to DATA with bit index 0.
  - DATA: sample at the sample point, shifting LSB-first into the shift register. After bit 7 go to STOP.
  - STOP: at the sample point:
    - Line=1: rx_data<=shift, rx_valid=1 next cycle, rx_first=(byte count==0). Update CRC over the byte, increment byte count (saturating at 1023), set baud_sel=hs, state IDLE. Returning at mid-stop allows resync on the next start edge.
    - Line=0, shift==0: break_det pulse. Clear the frame (CRC=0xFFFF, count=0, baud_sel=ls, no frame_end) and go to WAIT_HIGH.
    - Line=0, shift!=0: frame_err pulse. Drop the byte (no rx_valid, no CRC update) and go to WAIT_HIGH.
  - WAIT_HIGH: wait for line=1, then go to IDLE.
- CRC: CRC-16/MODBUS, reflected, poly 0xA001, init 0xFFFF, no final XOR, computed over every accepted byte including the appended CRC (low byte first). Use either a bitwise or a bytewise update; the result must be final before the next rx_valid.
- Idle counter: counts div_ls bit periods while state==IDLE and line=1, and saturates.
  - On reaching idle_len, bus_idle=1. If byte count > 0: frame_end=1 and crc_ok=(CRC==0) in the same cycle. Then CRC=0xFFFF, count=0, baud_sel=ls.
  - bus_idle falls on the clock after the start-edge detect.
  - idle_len=0 is treated as 1.
- Simultaneous events:
  - A start edge in the same cycle that the idle threshold is reached: frame_end is still issued first and the new character belongs to the next frame.
  - A false start does not restart a frame, but it does clear the idle counter.

Test Plan:
- div_ls=15, div_hs=3, idle_len=10. Send frame 0x01 (ls), 0x7E, 0x80 (hs), then idle -> 3 rx_valid strobes, rx_first on 0x01 only; frame_end after 10×16 idle clocks with crc_ok=1; bus_idle=1.
- Same frame with the last byte 0x81 -> frame_end with crc_ok=0; all three bytes still strobed.
- 0xA5 with stop bit forced low -> frame_err pulse, no rx_valid. Then 0x00 with stop low held 20 bit periods -> single break_det, no frame_end, no byte before line returns high.
- Low glitch of 5 clocks with div_ls=15 -> no output; idle counter restarts; bus_idle drops then re-asserts after 10 bit periods.
- Assert reset in DATA bit 4 of a byte -> all outputs 0 next cycle; byte discarded; the following clean frame starts with rx_first=1, CRC init 0xFFFF.
- After reset with rx held high, idle_len=3, div_ls=2 -> bus_idle rises after 9 clocks plus sync latency; no frame_end (byte count 0).
